// File: rtl/calc_sequencer.sv
// Calculator controller: debounced entry key, A/B operand entry, and a
// digit-serial signed BCD add/subtract producing D = A +/- B for the display block.
module calc_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_n,
  input  logic [9:0] sw_value,
  input  logic       sw_neg,
  input  logic       op_sub,
  output logic [9:0] A,
  output logic [9:0] B,
  output logic       negativeA,
  output logic       negativeB,
  output logic [9:0] D,
  output logic       negativeD,
  output logic       overflow,
  output logic       show_result,
  output logic       busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ENTER_A, S_ENTER_B, S_CMP, S_D0, S_D1, S_D2, S_SHOW
  } state_t;

  state_t state_reg, state_next;

  logic          sync1_reg, sync2_reg, key_level_reg, press_reg;
  logic [CW-1:0] db_cnt_reg;

  logic [9:0] a_reg, b_reg, x_reg, y_reg, d_reg;
  logic       neg_a_reg, neg_b_reg, sub_op_reg, sub_mode_reg, sign_reg;
  logic       invalid_reg, carry_reg, neg_d_reg, ovf_reg;
  logic [7:0] res_reg;

  // Key level is held as key_n polarity (1 = released); press fires on the accepted 1->0 change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg     <= 1'b1;
      sync2_reg     <= 1'b1;
      key_level_reg <= 1'b1;
      db_cnt_reg    <= '0;
      press_reg     <= 1'b0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == key_level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == CNT_LAST) begin
        key_level_reg <= sync2_reg;
        db_cnt_reg    <= '0;
        press_reg     <= ~sync2_reg;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  logic [3:0] x_digits [3];
  logic [3:0] y_digits [3];
  logic [1:0] bad_digit;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_digit
      if (gi < 2) begin : gen_bcd
        assign x_digits[gi] = x_reg[4*gi +: 4];
        assign y_digits[gi] = y_reg[4*gi +: 4];
        assign bad_digit[gi] = (a_reg[4*gi +: 4] > 4'd9) | (b_reg[4*gi +: 4] > 4'd9);
      end else begin : gen_hundreds
        assign x_digits[gi] = {2'b00, x_reg[9:8]};
        assign y_digits[gi] = {2'b00, y_reg[9:8]};
      end
    end
  endgenerate

  logic [3:0] xd, yd, dig;
  logic [4:0] sum, diff;
  logic       cout;

  always_comb begin
    xd = x_digits[0];
    yd = y_digits[0];
    case (state_reg)
      S_D1: begin xd = x_digits[1]; yd = y_digits[1]; end
      S_D2: begin xd = x_digits[2]; yd = y_digits[2]; end
      default: ;
    endcase
    sum  = {1'b0, xd} + {1'b0, yd} + {4'b0, carry_reg};
    diff = {1'b0, xd} - {1'b0, yd} - {4'b0, carry_reg};
    dig  = sum[3:0];
    cout = 1'b0;
    if (sub_mode_reg) begin
      // Borrow when the digit difference goes negative; wrap by adding ten.
      cout = diff[4];
      dig  = diff[4] ? diff[3:0] + 4'd10 : diff[3:0];
    end else if (sum > 5'd9) begin
      cout = 1'b1;
      dig  = sum[3:0] + 4'd6;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_ENTER_A: if (press_reg) state_next = S_ENTER_B;
      S_ENTER_B: if (press_reg) state_next = S_CMP;
      S_CMP:     state_next = S_D0;
      S_D0:      state_next = S_D1;
      S_D1:      state_next = S_D2;
      S_D2:      state_next = S_SHOW;
      S_SHOW:    if (press_reg) state_next = S_ENTER_A;
      default:   state_next = S_ENTER_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_ENTER_A;
    else          state_reg <= state_next;
  end

  logic [9:0] d_full;
  logic       eff_b;
  assign d_full = {dig[1:0], res_reg};
  assign eff_b  = neg_b_reg ^ sub_op_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0; b_reg <= '0; x_reg <= '0; y_reg <= '0; d_reg <= '0; res_reg <= '0;
      neg_a_reg <= 1'b0; neg_b_reg <= 1'b0; sub_op_reg <= 1'b0; sub_mode_reg <= 1'b0;
      sign_reg <= 1'b0; invalid_reg <= 1'b0; carry_reg <= 1'b0;
      neg_d_reg <= 1'b0; ovf_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_ENTER_A: begin
          a_reg     <= sw_value;
          neg_a_reg <= sw_neg;
        end
        S_ENTER_B: begin
          b_reg     <= sw_value;
          neg_b_reg <= sw_neg;
          if (press_reg) sub_op_reg <= op_sub;
        end
        S_CMP: begin
          carry_reg   <= 1'b0;
          invalid_reg <= |bad_digit;
          res_reg     <= '0;
          // Digit-wise BCD ordering matches plain unsigned ordering of the packed code.
          if (neg_a_reg == eff_b) begin
            sub_mode_reg <= 1'b0; x_reg <= a_reg; y_reg <= b_reg; sign_reg <= neg_a_reg;
          end else if (b_reg > a_reg) begin
            sub_mode_reg <= 1'b1; x_reg <= b_reg; y_reg <= a_reg; sign_reg <= eff_b;
          end else begin
            sub_mode_reg <= 1'b1; x_reg <= a_reg; y_reg <= b_reg; sign_reg <= neg_a_reg;
          end
        end
        S_D0: begin
          res_reg[3:0] <= dig;
          carry_reg    <= cout;
        end
        S_D1: begin
          res_reg[7:4] <= dig;
          carry_reg    <= cout;
        end
        S_D2: begin
          if (invalid_reg || cout || (dig > 4'd3)) begin
            d_reg <= '0; neg_d_reg <= 1'b0; ovf_reg <= 1'b1;
          end else begin
            d_reg     <= d_full;
            neg_d_reg <= sign_reg & (d_full != 10'd0);
            ovf_reg   <= 1'b0;
          end
        end
        S_SHOW: begin
          if (press_reg) begin
            d_reg <= '0; neg_d_reg <= 1'b0; ovf_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign A           = a_reg;
  assign B           = b_reg;
  assign negativeA   = neg_a_reg;
  assign negativeB   = neg_b_reg;
  assign D           = d_reg;
  assign negativeD   = neg_d_reg;
  assign overflow    = ovf_reg;
  assign show_result = (state_reg == S_SHOW);
  assign busy        = (state_reg == S_CMP) || (state_reg == S_D0) ||
                       (state_reg == S_D1) || (state_reg == S_D2);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: scoreboarded calculations, key debounce,
// held keys and asynchronous reset during compute.
module tb_calc_sequencer;

  localparam int DEB = 4;
  // Key falls before a clock edge: 2 sync stages + DEB samples + press cycle + CMP/D0/D1/D2.
  localparam int LAT = 2 + DEB + 5;

  logic       clk, reset_n, key_n, sw_neg, op_sub;
  logic [9:0] sw_value;
  logic [9:0] A, B, D;
  logic       negativeA, negativeB, negativeD, overflow, show_result, busy;

  calc_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .sw_value(sw_value), .sw_neg(sw_neg),
    .op_sub(op_sub), .A(A), .B(B), .negativeA(negativeA), .negativeB(negativeB),
    .D(D), .negativeD(negativeD), .overflow(overflow), .show_result(show_result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] d;
    logic       neg;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Hold key for 'hold' cycles, then keep watching long enough to debounce the release.
  task automatic key_press(input int hold, output int show_at, output logic [9:0] d_pre);
    show_at = -1;
    d_pre   = 10'h3ff;
    key_n   = 1'b0;
    for (int i = 1; i <= hold + 14; i++) begin
      @(negedge clk);
      if (i == hold) key_n = 1'b1;
      if (i == LAT - 1) d_pre = D;
      if (show_at < 0 && show_result === 1'b1) show_at = i;
    end
  endtask

  task automatic run_calc(input logic [9:0] a, input logic na, input logic [9:0] b,
                          input logic nb, input logic sub, input int hold_b,
                          input logic [9:0] ed, input logic en, input logic eo,
                          input string nm);
    int         s;
    logic [9:0] dp;
    exp_t       e;
    sw_value = a; sw_neg = na; op_sub = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++;
    if (A !== a || negativeA !== na) begin
      fails++; $display("FAIL %s A_track: A=%h negA=%b expected %h %b", nm, A, negativeA, a, na);
    end
    key_press(8, s, dp);
    sw_value = b; sw_neg = nb; op_sub = sub;
    @(negedge clk); @(negedge clk);
    tests++;
    if (A !== a || B !== b || negativeB !== nb || show_result !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s entry: A=%h B=%h negB=%b show=%b busy=%b expected %h %h %b 0 0",
               nm, A, B, negativeB, show_result, busy, a, b, nb);
    end
    e.d = ed; e.neg = en; e.ovf = eo;
    sb.push_back(e);
    key_press(hold_b, s, dp);
    tests++;
    if (s !== LAT) begin
      fails++; $display("FAIL %s latency: show_result at cycle %0d expected %0d", nm, s, LAT);
    end
    tests++;
    if (dp !== 10'h000) begin
      fails++; $display("FAIL %s early_D: D=%h one cycle before SHOW expected 000", nm, dp);
    end
    tests++;
    if (show_result !== 1'b1) begin
      fails++; $display("FAIL %s show_hold: show_result=%b expected 1", nm, show_result);
      sb.delete();
    end else begin
      e = sb.pop_front();
      tests++;
      if (D !== e.d) begin
        fails++; $display("FAIL %s D: got %h expected %h", nm, D, e.d);
      end
      tests++;
      if (negativeD !== e.neg || overflow !== e.ovf) begin
        fails++; $display("FAIL %s flags: negD=%b ovf=%b expected %b %b",
                          nm, negativeD, overflow, e.neg, e.ovf);
      end
    end
    key_press(8, s, dp);
    tests++;
    if (show_result !== 1'b0 || D !== 10'h000 || negativeD !== 1'b0 || overflow !== 1'b0 || A !== b) begin
      fails++;
      $display("FAIL %s clear: show=%b D=%h negD=%b ovf=%b A=%h expected 0 000 0 0 %h",
               nm, show_result, D, negativeD, overflow, A, b);
    end
    $display("[TB] %s: %h%s %s %h%s -> D=%h negD=%b ovf=%b", nm, a, na ? "(-)" : "",
             sub ? "-" : "+", b, nb ? "(-)" : "", ed, en, eo);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({A, B, D, negativeA, negativeB, negativeD, overflow, show_result, busy} !== 36'd0) begin
      fails++; $display("FAIL reset_state: A=%h B=%h D=%h flags=%b%b%b%b show=%b busy=%b expected all 0",
                        A, B, D, negativeA, negativeB, negativeD, overflow, show_result, busy);
    end
    reset_n = 1'b1;
    sw_value = 10'h321;
    @(negedge clk); @(negedge clk);
    tests++;
    if (A !== 10'h321) begin
      fails++; $display("FAIL reset_enter_a: A=%h expected 321", A);
    end
    $display("[TB] reset: outputs cleared, ENTER_A tracking switches");
  endtask

  task automatic test_add();
    run_calc(10'h123, 1'b0, 10'h045, 1'b0, 1'b0, 8, 10'h168, 1'b0, 1'b0, "add");
  endtask

  task automatic test_sub();
    run_calc(10'h045, 1'b0, 10'h123, 1'b0, 1'b1, 8, 10'h078, 1'b1, 1'b0, "sub_neg");
  endtask

  task automatic test_overflow();
    run_calc(10'h250, 1'b0, 10'h250, 1'b0, 1'b0, 8, 10'h000, 1'b0, 1'b1, "ovf_500");
    run_calc(10'h300, 1'b0, 10'h100, 1'b0, 1'b0, 8, 10'h000, 1'b0, 1'b1, "ovf_400");
    run_calc(10'h200, 1'b0, 10'h199, 1'b0, 1'b0, 8, 10'h399, 1'b0, 1'b0, "max_399");
  endtask

  task automatic test_neg_zero();
    run_calc(10'h100, 1'b1, 10'h100, 1'b1, 1'b1, 8, 10'h000, 1'b0, 1'b0, "neg_zero_sub");
    run_calc(10'h000, 1'b1, 10'h000, 1'b1, 1'b0, 8, 10'h000, 1'b0, 1'b0, "neg_zero_add");
  endtask

  task automatic test_invalid_digit();
    run_calc(10'h00A, 1'b0, 10'h001, 1'b0, 1'b0, 8, 10'h000, 1'b0, 1'b1, "bad_units");
  endtask

  task automatic test_back_to_back();
    run_calc(10'h399, 1'b1, 10'h001, 1'b0, 1'b0, 8, 10'h398, 1'b1, 1'b0, "b2b_1");
    run_calc(10'h019, 1'b0, 10'h081, 1'b1, 1'b1, 8, 10'h100, 1'b0, 1'b0, "b2b_2");
  endtask

  task automatic test_press_during_compute();
    // B key held 20 cycles spans the whole compute: no second press may leak through.
    run_calc(10'h012, 1'b0, 10'h034, 1'b0, 1'b0, 20, 10'h046, 1'b0, 1'b0, "held_key");
  endtask

  task automatic test_glitch();
    for (int g = 1; g <= 3; g++) begin
      key_n = 1'b0;
      repeat (g) @(negedge clk);
      key_n = 1'b1;
      repeat (8) @(negedge clk);
      sw_value = 10'(10'h100 + g);
      @(negedge clk); @(negedge clk);
      tests++;
      if (A !== 10'(10'h100 + g) || busy !== 1'b0) begin
        fails++; $display("FAIL glitch_%0d: A=%h busy=%b expected %h 0", g, A, busy, 10'(10'h100 + g));
      end
      $display("[TB] glitch of %0d cycles ignored check done", g);
    end
  endtask

  task automatic test_reset_mid_compute();
    logic spurious;
    sw_value = 10'h123; sw_neg = 1'b0; op_sub = 1'b0;
    @(negedge clk);
    key_n = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 8) key_n = 1'b1;
    end
    sw_value = 10'h045;
    sb.push_back(exp_t'{d: 10'h168, neg: 1'b0, ovf: 1'b0});
    key_n = 1'b0;
    for (int i = 1; i <= LAT - 2; i++) begin
      @(negedge clk);
      if (i == 8) key_n = 1'b1;
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL midreset_busy: busy=%b expected 1 in D1", busy);
    end
    reset_n = 1'b0;
    #1;
    sb.delete();
    tests++;
    if ({A, B, D, negativeA, negativeB, negativeD, overflow, show_result, busy} !== 36'd0) begin
      fails++; $display("FAIL midreset_async: A=%h B=%h D=%h ovf=%b show=%b busy=%b expected all 0",
                        A, B, D, overflow, show_result, busy);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (show_result !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    tests++;
    if (spurious !== 1'b0 || A !== 10'h045) begin
      fails++; $display("FAIL midreset_after: spurious=%b A=%h expected 0 045", spurious, A);
    end
    $display("[TB] reset during D1: returned to ENTER_A");
  endtask

  initial begin
    reset_n = 1'b0; key_n = 1'b1; sw_value = '0; sw_neg = 1'b0; op_sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_neg_zero();
    test_invalid_digit();
    test_back_to_back();
    test_press_during_compute();
    test_glitch();
    test_reset_mid_compute();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
